// File: rtl/nios2_debug_ocimem_seq_pkg.sv
// Shared types and jdo field positions for the OCIMEM debug-RAM sequencer.
package nios2_debug_ocimem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int JDO_W        = 38;
    localparam int JDO_ADDR_LSB = 2;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_RD_BIT   = 35;

    function automatic logic [31:0] jdo_data(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_DATA_LSB +: 32];
    endfunction

endpackage

// File: rtl/nios2_debug_ocimem_arb.sv
// Two-way RAM-port mux between the JTAG sequencer and the CPU debug slave,
// with a starvation counter that forces JTAG through after MAX_WAIT blocked cycles.
module nios2_debug_ocimem_arb #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_jtag_req,
    input  logic          i_jtag_we,
    input  logic [AW-1:0] i_jtag_addr,
    input  logic [31:0]   i_jtag_wdata,
    input  logic          i_cpu_window,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    output logic          o_jtag_win,
    output logic          o_cpu_gnt,
    output logic [AW-1:0] o_ram_addr,
    output logic [31:0]   o_ram_wdata,
    output logic          o_ram_we,
    output logic          o_ram_re
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_wait_cnt;
    logic          w_wait_done;

    assign w_wait_done = (r_wait_cnt == CW'(MAX_WAIT));
    assign o_jtag_win  = i_jtag_req && (!i_cpu_req || w_wait_done);
    // i_cpu_window and i_jtag_req are never high together, so grants are exclusive.
    assign o_cpu_gnt   = i_cpu_req && (i_cpu_window || (i_jtag_req && !w_wait_done));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (o_jtag_win) begin
            r_wait_cnt <= '0;
        end else if (i_jtag_req && i_cpu_req) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_comb begin
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_we    = 1'b0;
        o_ram_re    = 1'b0;
        if (o_jtag_win) begin
            o_ram_addr  = i_jtag_addr;
            o_ram_wdata = i_jtag_wdata;
            o_ram_we    = i_jtag_we;
            o_ram_re    = !i_jtag_we;
        end else if (o_cpu_gnt) begin
            o_ram_addr  = i_cpu_addr;
            o_ram_wdata = i_cpu_wdata;
            o_ram_we    = i_cpu_we;
            o_ram_re    = !i_cpu_we;
        end
    end

endmodule

// File: rtl/nios2_debug_ocimem_seq.sv
// System-clock OCIMEM sequencer: turns JTAG ocimem strobes into single-word RAM
// accesses, shares the RAM port with the CPU and maintains MonDReg/MonAReg/status.
module nios2_debug_ocimem_seq
    import nios2_debug_ocimem_seq_pkg::*;
#(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             take_action_ocimem_a,
    input  logic             take_action_ocimem_b,
    input  logic             take_no_action_ocimem_a,
    input  logic [JDO_W-1:0] jdo,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_gnt,
    output logic [AW-1:0]    ram_addr,
    output logic [31:0]      ram_wdata,
    output logic             ram_we,
    output logic             ram_re,
    input  logic [31:0]      ram_rdata,
    output logic [31:0]      MonDReg,
    output logic [AW-1:0]    MonAReg,
    output logic             monitor_ready,
    output logic             monitor_error,
    output state_e           o_dbg_state
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_pend;
    op_e           r_op;
    logic [31:0]   r_op_wdata;
    logic [AW-1:0] r_mon_a;
    logic [31:0]   r_mon_d;
    logic          r_ready;
    logic          r_error;

    logic w_busy;
    logic w_any_strobe;
    logic w_jtag_req;
    logic w_jtag_win;
    logic w_cpu_window;
    logic w_unused;

    // Handshake: a strobe is accepted only when nothing is queued or in flight
    // (monitor_ready high); anything else is dropped and flagged in monitor_error.
    assign w_busy       = r_pend || (r_state != ST_IDLE);
    assign w_any_strobe = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
    assign w_jtag_req   = (r_state == ST_REQ);
    assign w_cpu_window = ((r_state == ST_IDLE) && !r_pend) || (r_state == ST_RDATA);
    assign w_unused     = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_ADDR_LSB-1:0]};

    nios2_debug_ocimem_arb #(
        .AW       (AW),
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_jtag_req   (w_jtag_req),
        .i_jtag_we    (r_op == OP_WR),
        .i_jtag_addr  (r_mon_a),
        .i_jtag_wdata (r_op_wdata),
        .i_cpu_window (w_cpu_window),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_jtag_win   (w_jtag_win),
        .o_cpu_gnt    (cpu_gnt),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_we     (ram_we),
        .o_ram_re     (ram_re)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_pend) w_state_nxt = ST_REQ;
            ST_REQ:   if (w_jtag_win) w_state_nxt = (r_op == OP_WR) ? ST_IDLE : ST_RDATA;
            ST_RDATA: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= 1'b0;
            r_op       <= OP_RD;
            r_op_wdata <= '0;
            r_mon_a    <= '0;
            r_mon_d    <= '0;
            r_ready    <= 1'b1;
            r_error    <= 1'b0;
        end else begin
            if (w_any_strobe && w_busy) begin
                r_error <= 1'b1;
            end else if (!w_busy) begin
                // Write beats load-address beats plain read when strobes coincide.
                if (take_action_ocimem_b) begin
                    r_pend     <= 1'b1;
                    r_op       <= OP_WR;
                    r_op_wdata <= jdo_data(jdo);
                    r_ready    <= 1'b0;
                end else if (take_action_ocimem_a) begin
                    r_mon_a <= jdo[JDO_ADDR_LSB +: AW];
                    r_error <= 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        r_pend  <= 1'b1;
                        r_op    <= OP_RD;
                        r_ready <= 1'b0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    r_pend  <= 1'b1;
                    r_op    <= OP_RD;
                    r_ready <= 1'b0;
                end
            end

            if ((r_state == ST_IDLE) && r_pend) r_pend <= 1'b0;

            if ((r_state == ST_REQ) && w_jtag_win && (r_op == OP_WR)) begin
                r_mon_a <= r_mon_a + AW'(1);
                r_ready <= 1'b1;
            end

            if (r_state == ST_RDATA) begin
                r_mon_d <= ram_rdata;
                r_mon_a <= r_mon_a + AW'(1);
                r_ready <= 1'b1;
            end
        end
    end

    assign MonDReg       = r_mon_d;
    assign MonAReg       = r_mon_a;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_nios2_debug_ocimem_seq.sv
// Self-checking bench for nios2_debug_ocimem_seq: directed vector table, hand-written
// corner sequences and randomized JTAG ops against an array-based reference model.
module tb_nios2_debug_ocimem_seq;
    import nios2_debug_ocimem_seq_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        monitor_ready;
    logic        monitor_error;
    state_e      dbg_state;

    int n_checks;
    int n_errors;
    bit cpu_rand;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q[$];

    nios2_debug_ocimem_seq #(.AW(8), .MAX_WAIT(4)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .cpu_req                 (cpu_req),
        .cpu_we                  (cpu_we),
        .cpu_addr                (cpu_addr),
        .cpu_wdata               (cpu_wdata),
        .cpu_gnt                 (cpu_gnt),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_we                  (ram_we),
        .ram_re                  (ram_re),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .o_dbg_state             (dbg_state)
    );

    // ---- clock / reset block and RAM model ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // ---- checking helpers ----
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_rand) begin
            cpu_req  = 1'($urandom_range(0, 1));
            cpu_addr = 8'($urandom_range(0, 255));
            #1;
            if (cpu_gnt) begin
                chk("cpu_gnt_addr", {24'd0, ram_addr}, {24'd0, cpu_addr});
                chk("cpu_gnt_excl", {31'd0, ram_we && ram_re}, 32'd0);
            end
        end
    endtask

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a, 3 = ocimem_b + no_action together
    task automatic strobe(input int kind, input logic [7:0] addr, input logic [31:0] data, input bit rd);
        logic [37:0] v;
        v = '0;
        if (kind == 0) begin
            v[9:2] = addr;
            v[35]  = rd;
        end else begin
            v[34:3] = data;
        end
        jdo                     = v;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1) || (kind == 3);
        take_no_action_ocimem_a = (kind == 2) || (kind == 3);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 30; i++) begin
            if (monitor_ready) break;
            tick();
        end
        chk(name, {31'd0, monitor_ready}, 32'd1);
    endtask

    typedef struct {
        int          kind;   // 0 load+read, 1 write, 2 read
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic [7:0]  exp_a;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          n_gnt;
        bit          fired;
        logic        gnt_at_fire;
        logic [7:0]  ref_a;
        logic [31:0] ref_d;
        logic [7:0]  wr_a;

        n_checks = 0;
        n_errors = 0;
        cpu_rand = 1'b0;
        reset_n  = 1'b0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo       = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ram_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_monareg", {24'd0, MonAReg}, 32'd0);
        chk("rst_ready",   {31'd0, monitor_ready}, 32'd1);
        chk("rst_error",   {31'd0, monitor_error}, 32'd0);
        chk("rst_ram_strb", {30'd0, ram_we, ram_re}, 32'd0);
        chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);

        // ---- address load with read ----
        mem[8'h10] = 32'hDEADBEEF;
        strobe(0, 8'h10, 32'd0, 1'b1);
        chk("ldrd_ready_c1", {31'd0, monitor_ready}, 32'd0);
        tick();
        chk("ldrd_ready_c2", {31'd0, monitor_ready}, 32'd0);
        chk("ldrd_ram_re", {23'd0, ram_re, ram_addr}, {23'd0, 1'b1, 8'h10});
        tick();
        chk("ldrd_ready_c3", {31'd0, monitor_ready}, 32'd0);
        tick();
        chk("ldrd_mondreg", MonDReg, 32'hDEADBEEF);
        chk("ldrd_monareg", {24'd0, MonAReg}, 32'h11);
        chk("ldrd_ready_done", {31'd0, monitor_ready}, 32'd1);

        // ---- write with address wrap ----
        strobe(0, 8'hFF, 32'd0, 1'b0);
        chk("wrap_load", {24'd0, MonAReg}, 32'hFF);
        chk("wrap_load_ready", {31'd0, monitor_ready}, 32'd1);
        strobe(1, 8'd0, 32'h12345678, 1'b0);
        tick();
        chk("wrap_ram_we", {23'd0, ram_we, ram_addr}, {23'd0, 1'b1, 8'hFF});
        chk("wrap_wdata", ram_wdata, 32'h12345678);
        tick();
        chk("wrap_monareg", {24'd0, MonAReg}, 32'h00);
        chk("wrap_mem", mem[8'hFF], 32'h12345678);

        // ---- directed vector table ----
        mem[8'h20] = 32'hA5A5A5A5;
        mem[8'h22] = 32'h0BADF00D;
        mem[8'hFF] = 32'hCAFEF00D;
        mem[8'h00] = 32'h01020304;
        vecs[0] = '{0, 8'h20, 32'h0,        32'hA5A5A5A5, 8'h21};
        vecs[1] = '{1, 8'h00, 32'h11112222, 32'hA5A5A5A5, 8'h22};
        vecs[2] = '{2, 8'h00, 32'h0,        32'h0BADF00D, 8'h23};
        vecs[3] = '{0, 8'hFF, 32'h0,        32'hCAFEF00D, 8'h00};
        vecs[4] = '{2, 8'h00, 32'h0,        32'h01020304, 8'h01};
        vecs[5] = '{0, 8'h21, 32'h0,        32'h11112222, 8'h22};
        for (int v = 0; v < 6; v++) begin
            strobe(vecs[v].kind, vecs[v].addr, vecs[v].data, 1'b1);
            wait_ready($sformatf("vec%0d_ready", v));
            chk($sformatf("vec%0d_mondreg", v), MonDReg, vecs[v].exp_d);
            chk($sformatf("vec%0d_monareg", v), {24'd0, MonAReg}, {24'd0, vecs[v].exp_a});
        end

        // ---- CPU contention ----
        mem[8'h30] = 32'h30303030;
        strobe(0, 8'h30, 32'd0, 1'b0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h05;
        strobe(2, 8'd0, 32'd0, 1'b0);
        chk("cont_pend_gnt", {31'd0, cpu_gnt}, 32'd0);
        n_gnt = 0;
        fired = 1'b0;
        gnt_at_fire = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_re && ram_addr == 8'h30) begin
                fired = 1'b1;
                gnt_at_fire = cpu_gnt;
                break;
            end
            if (cpu_gnt) n_gnt++;
        end
        chk("cont_jtag_fired", {31'd0, fired}, 32'd1);
        chk("cont_gnt_cycles", n_gnt, 32'd4);
        chk("cont_gnt_at_fire", {31'd0, gnt_at_fire}, 32'd0);
        wait_ready("cont_ready");
        chk("cont_mondreg", MonDReg, 32'h30303030);
        cpu_req = 1'b0;

        // ---- busy error ----
        mem[8'h40] = 32'h44332211;
        strobe(0, 8'h40, 32'd0, 1'b0);
        strobe(2, 8'd0, 32'd0, 1'b0);
        tick();
        chk("busy_in_req", {30'd0, dbg_state}, {30'd0, ST_REQ});
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        chk("busy_error_set", {31'd0, monitor_error}, 32'd1);
        wait_ready("busy_ready");
        chk("busy_mondreg", MonDReg, 32'h44332211);
        chk("busy_monareg", {24'd0, MonAReg}, 32'h41);
        tick();
        chk("busy_no_replay", {30'd0, monitor_ready, ram_re}, 32'd2);
        strobe(0, 8'h50, 32'd0, 1'b0);
        chk("busy_error_clr", {31'd0, monitor_error}, 32'd0);

        // ---- simultaneous strobes ----
        strobe(0, 8'h60, 32'd0, 1'b0);
        strobe(3, 8'd0, 32'hA1B2C3D4, 1'b0);
        tick();
        chk("sim_we_only", {30'd0, ram_we, ram_re}, 32'd2);
        chk("sim_wdata", ram_wdata, 32'hA1B2C3D4);
        tick();
        chk("sim_monareg", {24'd0, MonAReg}, 32'h61);
        chk("sim_error", {31'd0, monitor_error}, 32'd0);
        tick();
        chk("sim_no_read", {30'd0, monitor_ready, ram_re}, 32'd2);
        chk("sim_mem", mem[8'h60], 32'hA1B2C3D4);

        // ---- randomized ops against reference model ----
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        cpu_rand = 1'b1;
        ref_a = 8'($urandom_range(0, 255));
        ref_d = 32'd0;
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [7:0]  a;
            logic [31:0] d;
            kind = (n == 0) ? 1 : $urandom_range(0, 3);
            a    = (n == 0) ? ref_a : 8'($urandom_range(0, 255));
            d    = $urandom;
            wr_a = ref_a;
            case (kind)
                0: begin
                    ref_a = a;
                    strobe(0, a, 32'd0, 1'b0);
                end
                1: begin
                    ref_a = a;
                    exp_q.push_back(ref_mem[ref_a]);
                    ref_a = ref_a + 8'd1;
                    strobe(0, a, 32'd0, 1'b1);
                end
                2: begin
                    ref_mem[ref_a] = d;
                    ref_a = ref_a + 8'd1;
                    strobe(1, 8'd0, d, 1'b0);
                end
                default: begin
                    exp_q.push_back(ref_mem[ref_a]);
                    ref_a = ref_a + 8'd1;
                    strobe(2, 8'd0, 32'd0, 1'b0);
                end
            endcase
            wait_ready($sformatf("rnd%0d_ready", n));
            if (exp_q.size() > 0) ref_d = exp_q.pop_front();
            chk($sformatf("rnd%0d_mondreg", n), MonDReg, ref_d);
            chk($sformatf("rnd%0d_monareg", n), {24'd0, MonAReg}, {24'd0, ref_a});
            chk($sformatf("rnd%0d_error", n), {31'd0, monitor_error}, 32'd0);
            if (kind == 2) chk($sformatf("rnd%0d_mem", n), mem[wr_a], ref_mem[wr_a]);
        end
        cpu_rand = 1'b0;
        cpu_req  = 1'b0;

        // ---- reset mid-transfer ----
        mem[8'h70] = 32'h55AA55AA;
        strobe(0, 8'h70, 32'd0, 1'b0);
        strobe(2, 8'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk("rstmid_in_rdata", {30'd0, dbg_state}, {30'd0, ST_RDATA});
        reset_n = 1'b0;
        #1;
        chk("rstmid_mondreg", MonDReg, 32'd0);
        chk("rstmid_ready", {31'd0, monitor_ready}, 32'd1);
        chk("rstmid_monareg", {24'd0, MonAReg}, 32'd0);
        chk("rstmid_ram_re", {31'd0, ram_re}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rstmid_idle%0d", i), {29'd0, ram_re, monitor_ready, MonDReg == 32'd0}, 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios2_debug_ocimem_seq.md
Name: nios2_debug_ocimem_seq

Overview:
- System-clock-side sequencer for the on-chip debug RAM (OCIMEM) in the Nios II debug slave.
- Decodes the take_action_ocimem_* strobes and jdo payload produced by the debug slave wrapper into single-word RAM reads and writes.
- Shares the single RAM port between JTAG-initiated accesses and the CPU debug-memory slave.
- Maintains MonDReg, monitor_ready and monitor_error, which are fed back to the debug slave TCK logic.

Parameters:
- AW, 8, OCIMEM word-address width (256 x 32-bit words).
- MAX_WAIT, 4, consecutive cycles a pending JTAG access may be blocked by the CPU before JTAG is forced to win.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- take_action_ocimem_a  in  1  one-cycle strobe: load address (optional read)
- take_action_ocimem_b  in  1  one-cycle strobe: write data at current address, then auto-increment
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address, then auto-increment
- jdo  in  38  JTAG data-out payload, stable while any strobe is high
- cpu_req  in  1  CPU slave access request
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- ram_addr  out  AW  RAM address
- ram_wdata  out  32  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe; ram_rdata is valid on the next cycle
- ram_rdata  in  32  RAM read data
- MonDReg  out  32  monitor data register
- MonAReg  out  AW  current JTAG word address
- monitor_ready  out  1  high when no JTAG access is pending
- monitor_error  out  1  sticky error: strobe arrived while busy

Behaviour:
- Reset: all outputs 0 except monitor_ready=1. State=IDLE.
- Command decode (accepted only in IDLE):
  - ocimem_a: MonAReg<=jdo[AW+1:2]. If jdo[35]=1, queue a read; otherwise no RAM access.
  - ocimem_b: queue a write of jdo[34:3] at MonAReg.
  - no_action_ocimem_a: queue a read at MonAReg.
  - An accepted ocimem_a also clears monitor_error.
- Priority for simultaneous strobes: ocimem_b > ocimem_a > no_action_ocimem_a. Lower-priority strobes are ignored; no error is raised.
- States:
  - IDLE: a queued op moves to REQ in the next cycle. monitor_ready falls in that same cycle.
  - REQ: JTAG wins if cpu_req=0 or wait_cnt==MAX_WAIT. Otherwise cpu_gnt=1 and wait_cnt increments.
    - JTAG write wins: drive ram_we, then go to IDLE.
    - JTAG read wins: drive ram_re, then go to RDATA.
    - wait_cnt clears on every JTAG win.
  - RDATA: MonDReg<=ram_rdata, then go to IDLE.
- Completion: after each JTAG write or read completion, MonAReg<=MonAReg+1, wrapping modulo 2^AW (address 2^AW-1 wraps to 0). monitor_ready rises on return to IDLE.
- Latency: ocimem_b strobe to ram_we is 2 cycles when uncontended. no_action read strobe to MonDReg update is 3 cycles.
- Any strobe while state!=IDLE sets monitor_error=1 and is dropped; the in-flight op is unaffected.
- CPU access when no JTAG op is pending: cpu_gnt=cpu_req in IDLE and RDATA. The RAM is driven from the cpu_* inputs.
- ram_we/ram_re are never asserted for both sources in one cycle.
- reset_n low mid-operation: immediate return to reset values; the pending op is discarded.

Decomposition:
- Shared package: state enum (IDLE, REQ, RDATA), jdo field positions (address LSB=2, data LSB=3, read flag=35), op-code constants.
- One sub-module: nios2_debug_ocimem_arb, the 2-way RAM-port mux with the MAX_WAIT starvation counter.

Test Plan:
- Reset mid-transfer:
  - Stimulus: assert reset_n=0 while in RDATA.
  - Required: MonDReg=0, monitor_ready=1, no further ram_re.
- Address load with read:
  - Stimulus: ocimem_a with address field 0x10 and jdo[35]=1; RAM holds 0xDEADBEEF at word 0x10.
  - Required: MonDReg=0xDEADBEEF 3 cycles after the strobe; MonAReg=0x11; monitor_ready 0 for 3 cycles.
- Write with address wrap:
  - Stimulus: MonAReg=0xFF, ocimem_b with data 0x12345678.
  - Required: ram_we at address 0xFF with wdata 0x12345678; MonAReg wraps to 0x00.
- CPU contention:
  - Stimulus: cpu_req held high; JTAG read pending.
  - Required: cpu_gnt high for exactly 4 cycles, then the JTAG ram_re fires; cpu_gnt=0 in that cycle.
- Busy error:
  - Stimulus: second no_action strobe while in REQ.
  - Required: monitor_error=1, first op completes normally, next ocimem_a clears monitor_error.
- Simultaneous strobes:
  - Stimulus: ocimem_b and no_action_ocimem_a in the same cycle.
  - Required: only the write is performed; monitor_error stays 0.
